// File: rtl/fft_result_streamer.sv
// fft_result_streamer
//   Drains one computed frame out of the FFT result SRAM and presents it as a
//   valid/ready stream in natural frequency order. By default the SRAM is read
//   in bit-reversed address order.
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-low reset
//   start            one-cycle frame request; ignored unless idle
//   busy             frame in progress
//   done             one-cycle pulse after the last word's handshake
//   mem_cs, mem_w    SRAM chip select (read issue) and write enable (always 0)
//   mem_addr         SRAM read address
//   mem_rdata        SRAM read data, valid the cycle after mem_cs
//   out_valid/ready  output stream handshake
//   out_data         stream word (opaque payload)
//   out_index        natural frequency index of out_data
//   out_last         marks the word with the highest index
//
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both 1. While out_valid is 1 and out_ready is 0, out_valid,
// out_data, out_index and out_last hold stable; out_valid never depends on
// out_ready.

module fft_result_streamer #(
  parameter int N_LOG2 = 11,
  parameter int AW     = 12,
  parameter int DW     = 41,
  parameter int BITREV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_cs,
  output logic              mem_w,
  output logic [AW-1:0]     mem_addr,
  input  logic [DW-1:0]     mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [N_LOG2-1:0] out_index,
  output logic              out_last
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [N_LOG2:0] LAST_ISSUE = (N_LOG2+1)'((1 << N_LOG2) - 1);

  state_t              state;
  logic [N_LOG2:0]     issue_cnt;     // one extra bit so a full frame count fits
  logic                inflight;      // a read was issued last cycle
  logic [N_LOG2-1:0]   inflight_idx;  // natural index of that read
  logic                done_r;

  // Two-entry FIFO holding words together with their natural index.
  logic [DW-1:0]       fifo_data [2];
  logic [N_LOG2-1:0]   fifo_idx  [2];
  logic                rd_ptr;
  logic                wr_ptr;
  logic [1:0]          count;

  logic                pop;
  logic                push;
  logic                issue;
  logic [2:0]          occ;
  logic [2:0]          occ_limit;
  logic [N_LOG2-1:0]   issue_idx;
  logic [N_LOG2-1:0]   rd_addr;

  function automatic logic [N_LOG2-1:0] bit_reverse(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = v[N_LOG2-1-i];
    return r;
  endfunction

  assign pop       = (count != 2'd0) && out_ready;
  assign push      = inflight;
  // Words already held plus the one arriving must leave room for the new
  // read once this cycle's pop is accounted for.
  assign occ       = {1'b0, count} + {2'b00, inflight};
  assign occ_limit = 3'd2 + {2'b00, pop};
  assign issue     = (state == RUN) && (occ < occ_limit);
  assign issue_idx = issue_cnt[N_LOG2-1:0];
  assign rd_addr   = (BITREV != 0) ? bit_reverse(issue_idx) : issue_idx;

  assign mem_cs    = issue;
  assign mem_w     = 1'b0;
  assign mem_addr  = issue ? AW'(rd_addr) : '0;

  assign busy      = (state != IDLE);
  assign done      = done_r;
  assign out_valid = (count != 2'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_index = fifo_idx[rd_ptr];
  assign out_last  = out_valid && (&out_index);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      issue_cnt    <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      done_r       <= 1'b0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_idx[0]  <= '0;
      fifo_idx[1]  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            issue_cnt <= '0;
          end
        end
        RUN: begin
          if (issue && (issue_cnt == LAST_ISSUE)) state <= DRAIN;
        end
        DRAIN: begin
          // done_r is high for the single cycle before returning to IDLE.
          if (done_r) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Final handshake: one word left, nothing in flight, all reads issued.
      done_r <= (state == DRAIN) && !done_r && (count == 2'd1) && !inflight && pop;

      inflight <= issue;
      if (issue) begin
        issue_cnt    <= issue_cnt + 1'b1;
        inflight_idx <= issue_idx;
      end

      if (push) begin
        fifo_data[wr_ptr] <= mem_rdata;
        fifo_idx[wr_ptr]  <= inflight_idx;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // The issue rule must never let a push land on a full FIFO.
  always_ff @(posedge clk) begin
    if (rst && push && !pop) assert (count != 2'd2);
  end

endmodule

// File: tb/tb_fft_result_streamer.sv
// Bench for fft_result_streamer: a BITREV=1 and a BITREV=0 instance share
// the clock, reset and a behavioural SRAM image; one is exercised at a time.

module tb_fft_result_streamer;

  localparam int N_LOG2 = 11;
  localparam int AW     = 12;
  localparam int DW     = 41;
  localparam int N      = 1 << N_LOG2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic sel = 1'b0;  // 0 = bit-reversed instance, 1 = linear instance

  logic [DW-1:0] mem [N];

  logic              b_busy, b_done, b_cs, b_w, b_valid, b_last;
  logic [AW-1:0]     b_addr;
  logic [DW-1:0]     b_rdata, b_data;
  logic [N_LOG2-1:0] b_index;
  logic              l_busy, l_done, l_cs, l_w, l_valid, l_last;
  logic [AW-1:0]     l_addr;
  logic [DW-1:0]     l_rdata, l_data;
  logic [N_LOG2-1:0] l_index;

  fft_result_streamer #(.N_LOG2(N_LOG2), .AW(AW), .DW(DW), .BITREV(1)) u_dut (
    .clk(clk), .rst(rst), .start(start && !sel), .busy(b_busy), .done(b_done),
    .mem_cs(b_cs), .mem_w(b_w), .mem_addr(b_addr), .mem_rdata(b_rdata),
    .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data),
    .out_index(b_index), .out_last(b_last)
  );

  fft_result_streamer #(.N_LOG2(N_LOG2), .AW(AW), .DW(DW), .BITREV(0)) u_lin (
    .clk(clk), .rst(rst), .start(start && sel), .busy(l_busy), .done(l_done),
    .mem_cs(l_cs), .mem_w(l_w), .mem_addr(l_addr), .mem_rdata(l_rdata),
    .out_valid(l_valid), .out_ready(out_ready), .out_data(l_data),
    .out_index(l_index), .out_last(l_last)
  );

  // SRAM with one-cycle registered read, one read port per instance.
  always @(posedge clk) begin
    if (b_cs) b_rdata <= mem[b_addr[N_LOG2-1:0]];
    if (l_cs) l_rdata <= mem[l_addr[N_LOG2-1:0]];
  end

  logic              c_busy, c_done, c_cs, c_w, c_valid, c_last;
  logic [AW-1:0]     c_addr;
  logic [DW-1:0]     c_data;
  logic [N_LOG2-1:0] c_index;
  assign c_busy  = sel ? l_busy  : b_busy;
  assign c_done  = sel ? l_done  : b_done;
  assign c_cs    = sel ? l_cs    : b_cs;
  assign c_w     = sel ? l_w     : b_w;
  assign c_valid = sel ? l_valid : b_valid;
  assign c_last  = sel ? l_last  : b_last;
  assign c_addr  = sel ? l_addr  : b_addr;
  assign c_data  = sel ? l_data  : b_data;
  assign c_index = sel ? l_index : b_index;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference bit reversal by repeated division.
  function automatic int rev_ref(input int x);
    int r = 0;
    int v = x;
    for (int b = 0; b < N_LOG2; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      64'(c_busy),  64'd0);
    check({tag, "_done"},      64'(c_done),  64'd0);
    check({tag, "_mem_cs"},    64'(c_cs),    64'd0);
    check({tag, "_mem_w"},     64'(c_w),     64'd0);
    check({tag, "_mem_addr"},  64'(c_addr),  64'd0);
    check({tag, "_out_valid"}, 64'(c_valid), 64'd0);
    check({tag, "_out_data"},  64'(c_data),  64'd0);
    check({tag, "_out_index"}, 64'(c_index), 64'd0);
    check({tag, "_out_last"},  64'(c_last),  64'd0);
  endtask

  // ---------------- driver + scoreboard ----------------
  // mode: 0 = ready held 1, 1 = random 50% ready, 2 = ready 0 until cycle 40
  task automatic run_frame(input bit lin, input int mode, input int restart_at, input int reset_at);
    logic [DW-1:0]     exp_q[$];
    logic [DW-1:0]     exp_w;
    logic [DW-1:0]     prev_data;
    logic [N_LOG2-1:0] prev_idx;
    int cyc, issues, hs, dones, done_cyc, first_cs, first_valid, max_out;
    bit stalled, fin, aborted, restarted, rst_fired, rst_prev;

    sel = lin;
    for (int i = 0; i < N; i++) exp_q.push_back(mem[lin ? i : rev_ref(i)]);
    cyc = 0; issues = 0; hs = 0; dones = 0; done_cyc = -1;
    first_cs = -1; first_valid = -1; max_out = 0;
    stalled = 0; fin = 0; aborted = 0; restarted = 0; rst_fired = 0; rst_prev = 0;
    prev_data = '0; prev_idx = '0;

    @(negedge clk);
    start = 1'b1;
    out_ready = (mode == 0);
    #1;
    check("busy_cycle0", 64'(c_busy), 64'd0);

    while (!fin && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      rst = 1'b1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc >= 40);
      endcase
      if (restart_at >= 0 && hs >= restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1;
      end
      if (reset_at >= 0 && hs >= reset_at && !rst_fired) begin
        rst = 1'b0;
        out_ready = 1'b0;
        rst_fired = 1;
      end
      #1;
      if (rst_prev) begin
        check_idle_outputs("after_reset");
        aborted = 1;
        fin = 1;
      end else begin
        if (c_cs) begin
          check("issue_addr", 64'(c_addr), 64'(lin ? issues : rev_ref(issues)));
          if (first_cs < 0) first_cs = cyc;
          issues++;
        end
        check("mem_w", 64'(c_w), 64'd0);
        if (stalled) begin
          check("stall_valid", 64'(c_valid), 64'd1);
          check("stall_data",  64'(c_data),  64'(prev_data));
          check("stall_index", 64'(c_index), 64'(prev_idx));
        end
        if (c_valid && first_valid < 0) first_valid = cyc;
        if (mode == 2 && cyc == 39) begin
          check("hold_issues", 64'(issues), 64'd2);
          check("hold_valid",  64'(c_valid), 64'd1);
          check("hold_data",   64'(c_data),  64'(exp_q.size() > 0 ? exp_q[0] : '0));
        end
        if (c_valid && out_ready && rst) begin
          if (exp_q.size() == 0) check("extra_word", 64'd1, 64'd0);
          else begin
            exp_w = exp_q.pop_front();
            check("data",  64'(c_data),  64'(exp_w));
            check("index", 64'(c_index), 64'(hs));
            check("last",  64'(c_last),  64'(hs == N - 1));
          end
          hs++;
        end
        stalled   = c_valid && !out_ready && rst;
        prev_data = c_data;
        prev_idx  = c_index;
        if (issues - hs > max_out) max_out = issues - hs;
        if (done_cyc >= 0 && cyc == done_cyc + 1) begin
          check("busy_after_done", 64'(c_busy), 64'd0);
          check("done_single",     64'(c_done), 64'd0);
          fin = 1;
        end
        if (c_done) begin
          dones++;
          if (done_cyc < 0) done_cyc = cyc;
        end
      end
      rst_prev = !rst;
    end

    rst = 1'b1;
    start = 1'b0;
    if (!fin) check("frame_timeout", 64'd0, 64'd1);
    if (!aborted) begin
      check("handshakes",  64'(hs),           64'(N));
      check("issues",      64'(issues),       64'(N));
      check("done_pulses", 64'(dones),        64'd1);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("outstanding", 64'(max_out <= 2), 64'd1);
      if (mode == 0) begin
        check("first_cs_cycle",    64'(first_cs),    64'd1);
        check("first_valid_cycle", 64'(first_valid), 64'd3);
        check("done_cycle",        64'(done_cyc),    64'd2051);
      end
    end
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] rnd;
    for (int a = 0; a < N; a++) mem[a] = DW'(a);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    run_frame(1'b0, 0, -1, -1);   // bit-reversed, full throughput
    run_frame(1'b1, 0, -1, -1);   // linear order
    run_frame(1'b0, 2, -1, -1);   // ready held low after start

    for (int a = 0; a < N; a++) begin
      rnd = {$urandom(), $urandom()};
      mem[a] = rnd[DW-1:0];
    end
    run_frame(1'b0, 1, -1, -1);   // random backpressure
    run_frame(1'b0, 0, 500, -1);  // start re-pulsed mid-frame
    run_frame(1'b0, 1, -1, 100);  // reset mid-frame
    run_frame(1'b0, 1, -1, -1);   // clean frame after abort

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_result_streamer.md
Name: fft_result_streamer

Overview:
- Downstream consumer of the 2048-entry, 41-bit FFT result SRAM.
- After a frame is computed, it sweeps all 2048 words out of the SRAM through its chip-select/read port. Sweep order is bit-reversed by default, so output leaves in natural frequency order.
- Presents the words on a valid/ready stream to the next stage (output formatter / host interface).
- Absorbs the SRAM's one-cycle registered read latency and downstream backpressure with a 2-entry buffer. No words are lost or duplicated.

Parameters:
- N_LOG2, 11, log2 of frame length (2048 points).
- AW, 12, SRAM address width; address bits above N_LOG2 are driven 0.
- DW, 41, SRAM/stream word width (opaque payload, passed unmodified).
- BITREV, 1, 1 = read address is the N_LOG2-bit bit-reverse of the output index; 0 = linear.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to stream a frame; honoured only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last word's handshake.
- mem_cs  out  1  SRAM chip select; high only on read-issue cycles.
- mem_w  out  1  SRAM write enable; constant 0.
- mem_addr  out  AW  SRAM read address.
- mem_rdata  in  DW  SRAM data_out; valid the cycle after mem_cs was high.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accept.
- out_data  out  DW  stream word.
- out_index  out  N_LOG2  natural output index of out_data (0..2047).
- out_last  out  1  high with the word at out_index = 2^N_LOG2−1.

Behaviour:
- Reset (rst=0 at a clock edge) takes effect at that edge:
  - State goes to IDLE; FIFO is emptied; issue counter and in-flight flag are cleared.
  - busy, done, mem_cs, mem_w, out_valid and out_last are 0; mem_addr, out_data and out_index are 0.
- Reset mid-frame aborts the sweep. Read data returning the cycle after reset is discarded.
- States:
  - IDLE: start=1 → RUN; issue counter ← 0.
  - RUN: issues reads until 2^N_LOG2 reads are issued → DRAIN.
  - DRAIN: waits for the FIFO and the in-flight read to empty via handshakes. After the last handshake, done=1 for one cycle and state → IDLE.
  - start in RUN or DRAIN is ignored.
- Read issue:
  - Condition: in RUN, and fifo_count + inflight − pop < 2, where pop = out_valid & out_ready this cycle.
  - On issue: mem_cs=1, mem_addr = BITREV ? bitrev(issue_cnt) : issue_cnt; issue_cnt increments; inflight ← 1 for next cycle; else inflight ← 0.
- Capture: the cycle after an issue, mem_rdata is written into the FIFO with its index. Push and pop in the same cycle are both honoured.
- FIFO: 2 entries. out_valid = (count ≠ 0). out_data, out_index and out_last come from the head and hold stable while out_valid & !out_ready. The issue rule guarantees overflow never occurs; overflow is an assertion failure.
- Latency: start high in cycle 0 → mem_cs in cycle 1 → out_valid in cycle 3.
- Throughput: with out_ready held 1, one word per cycle. A full frame completes its last handshake in cycle 2050; done in cycle 2051; busy low in cycle 2052.
- Counter width: issue_cnt is N_LOG2+1 bits, so 2048 is representable; it does not wrap within a frame.

Test Plan:
- Full frame, BITREV=1, memory[a]=a, out_ready=1: start → out_data 0,1024,512,1536,256,… with out_index 0..2047. out_last only on index 2047 (data 2047). Exactly 2048 handshakes; done in cycle 2051.
- BITREV=0, same preload: out_data equals out_index for all 2048 words. mem_addr bit 11 is always 0.
- out_ready held 0 after start: exactly 2 mem_cs pulses (addresses 0 and 1024), then mem_cs stays 0. out_data holds 0 and out_valid stays 1 until ready rises.
- Random 50% out_ready over a full frame: no loss or duplication (scoreboard against bit-reversed expected order). out_data is stable during every stall. The FIFO never exceeds 2.
- start pulsed again at word 500 while busy: ignored; the frame completes normally with a single done pulse.
- rst=0 for one cycle at word 100: the next cycle all outputs are at reset values. A fresh start restarts from out_index 0, address 0, with no stale word emitted.
